// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO serial drain block.
//   DATA_W_DEF : default word width, matches the register FIFO
//   state_t    : drain FSM state encoding (3 bits)
//   ser_t      : serial line output bundle
//   cnt_w      : counter width helper that never returns 0
package fifo_pkg;

  localparam int DATA_W_DEF = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    LOAD   = 3'd2,
    SHIFT  = 3'd3,
    GAP_ST = 3'd4
  } state_t;

  typedef struct packed {
    logic data;
    logic frame;
    logic bit_stb;
  } ser_t;

  // Width of a counter holding 0..n-1; a 1-bit counter when n <= 2.
  function automatic int cnt_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bit_rate_gen.sv
// Bit period divider for the serial drain.
//   clk, rstn : clock, async active-low reset
//   clr       : synchronous clear (asserted while the FSM is in LOAD)
//   run       : divider advances only while high (FSM in SHIFT)
//   bit_start : high on the first clk of each bit period
//   bit_end   : high on the last clk of each bit period
// With CLK_DIV=1 both strobes are high on every running cycle.
module bit_rate_gen
  import fifo_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic run,
  output logic bit_start,
  output logic bit_end
);

  localparam int            DW       = cnt_w(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)      div_q <= '0;
    else if (clr)   div_q <= '0;
    else if (run)   div_q <= (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
  end

  // Strobes decode registered state only, so they are glitch-safe outputs.
  assign bit_start = run && (div_q == '0);
  assign bit_end   = run && (div_q == DIV_LAST);

endmodule

// File: rtl/fifo_serial_drain.sv
// Pops words from the register FIFO and shifts them out as framed serial data.
//   clk, rstn   : clock, async active-low reset
//   en          : drain enable, looked at only when idle
//   fifo_empty  : FIFO empty flag
//   fifo_dout   : FIFO read data, valid the cycle after fifo_rd
//   fifo_rd     : one-cycle read pulse
//   ser_data    : serial bit, held CLK_DIV clks per bit
//   ser_frame   : high for every data/parity bit of a frame
//   ser_bit_stb : pulse on the first clk of each bit
//   busy        : high outside IDLE
//   word_done   : pulse on the last clk of the last bit
//   word_cnt    : completed frames, wraps naturally
// Timing: REQ (fifo_rd) at T, LOAD at T+1, first bit at T+2. Between
// back-to-back frames ser_frame is low for GAP + 3 clks (GAP, IDLE, REQ, LOAD).
module fifo_serial_drain
  import fifo_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int CLK_DIV   = 4,
  parameter int GAP       = 2,
  parameter int MSB_FIRST = 1,
  parameter int PARITY_EN = 0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              en,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              fifo_rd,
  output logic              ser_data,
  output logic              ser_frame,
  output logic              ser_bit_stb,
  output logic              busy,
  output logic              word_done,
  output logic [15:0]       word_cnt
);

  localparam int            NBITS    = DATA_W + PARITY_EN;
  localparam int            BW       = $clog2(DATA_W + 2);
  localparam logic [BW-1:0] BIT_LAST = BW'(NBITS - 1);
  localparam int            GW       = cnt_w(GAP);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);
  localparam int            SW       = DATA_W + 1;

  state_t        state_q, state_d;
  logic [SW-1:0] sr_q;
  logic [BW-1:0] bit_q;
  logic [GW-1:0] gap_q;
  logic          in_shift, last_bit, bit_start, bit_end;
  logic          head_bit;
  ser_t          ser;

  assign in_shift = (state_q == SHIFT);
  assign last_bit = (bit_q == BIT_LAST);
  // The parity bit rides in the extra shift register slot behind the data,
  // so it falls out after the data bits without a separate mux.
  assign head_bit = (MSB_FIRST != 0) ? sr_q[SW-1] : sr_q[0];

  bit_rate_gen #(.CLK_DIV(CLK_DIV)) u_brg (
    .clk      (clk),
    .rstn     (rstn),
    .clr      (state_q == LOAD),
    .run      (in_shift),
    .bit_start(bit_start),
    .bit_end  (bit_end)
  );

  // Next state and outputs, all decoded from registered state.
  always_comb begin
    state_d     = state_q;
    fifo_rd     = 1'b0;
    busy        = (state_q != IDLE);
    word_done   = 1'b0;
    ser         = '0;
    unique case (state_q)
      IDLE:   if (en && !fifo_empty) state_d = REQ;
      REQ: begin
        fifo_rd = 1'b1;
        state_d = LOAD;
      end
      LOAD:   state_d = SHIFT;
      SHIFT: begin
        ser.frame   = 1'b1;
        ser.data    = head_bit;
        ser.bit_stb = bit_start;
        if (bit_end && last_bit) begin
          word_done = 1'b1;
          state_d   = (GAP == 0) ? IDLE : GAP_ST;
        end
      end
      GAP_ST: if (gap_q == GAP_LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign ser_data    = ser.data;
  assign ser_frame   = ser.frame;
  assign ser_bit_stb = ser.bit_stb;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      sr_q     <= '0;
      bit_q    <= '0;
      gap_q    <= '0;
      word_cnt <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        LOAD: begin
          // Even parity: parity bit = XOR of data, total ones count even.
          sr_q  <= (MSB_FIRST != 0) ? {fifo_dout, ^fifo_dout}
                                    : {^fifo_dout, fifo_dout};
          bit_q <= '0;
          gap_q <= '0;
        end
        SHIFT: if (bit_end) begin
          if (last_bit) begin
            word_cnt <= word_cnt + 16'd1;
          end else begin
            bit_q <= bit_q + 1'b1;
            sr_q  <= (MSB_FIRST != 0) ? (sr_q << 1) : (sr_q >> 1);
          end
        end
        GAP_ST: gap_q <= gap_q + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_serial_drain.sv
// Bench for fifo_serial_drain: lane 0 without parity, lane 1 with parity.
// A FIFO model feeds each lane; a monitor collects frames into a queue that
// the test tasks pop and compare against words queued at stimulus time.
module tb_fifo_serial_drain;

  localparam int DW = 16;
  localparam int CD = 4;
  localparam int GP = 2;

  typedef struct {
    logic [16:0] bits;
    int          nbits;
    int          ncyc;
    int          lat;
    int          gap;
    bit          unstable;
  } frm_t;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          en [2];
  logic          fifo_empty [2];
  logic [DW-1:0] fifo_dout [2];
  logic          fifo_rd [2];
  logic          ser_data [2];
  logic          ser_frame [2];
  logic          ser_bit_stb [2];
  logic          busy [2];
  logic          word_done [2];
  logic [15:0]   word_cnt [2];

  logic [DW-1:0] fq [2][$];
  logic [16:0]   expq [2][$];
  frm_t          obs [2][$];
  frm_t          cur [2];
  bit            in_f [2];
  logic          prev [2];
  int            cyc, rd_cyc [2], low_run [2], n_rd [2], rd_viol [2], n_done [2];
  int            tests = 0, fails = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    fifo_serial_drain #(
      .DATA_W(DW), .CLK_DIV(CD), .GAP(GP), .MSB_FIRST(1), .PARITY_EN(g)
    ) u_dut (
      .clk        (clk),
      .rstn       (rstn),
      .en         (en[g]),
      .fifo_empty (fifo_empty[g]),
      .fifo_dout  (fifo_dout[g]),
      .fifo_rd    (fifo_rd[g]),
      .ser_data   (ser_data[g]),
      .ser_frame  (ser_frame[g]),
      .ser_bit_stb(ser_bit_stb[g]),
      .busy       (busy[g]),
      .word_done  (word_done[g]),
      .word_cnt   (word_cnt[g])
    );
  end

  // FIFO model: read data appears the cycle after fifo_rd.
  initial begin
    forever begin
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
        if (fifo_rd[i] && fq[i].size() > 0) fifo_dout[i] <= fq[i].pop_front();
        fifo_empty[i] <= (fq[i].size() == 0);
      end
    end
  end

  function automatic void clr_cur(input int i);
    cur[i].bits = '0; cur[i].nbits = 0; cur[i].ncyc = 0;
    cur[i].lat = 0; cur[i].gap = 0; cur[i].unstable = 0;
  endfunction

  // Frame monitor, sampling on the falling edge.
  initial begin
    cyc = 0;
    for (int i = 0; i < 2; i++) begin
      clr_cur(i); in_f[i] = 0; prev[i] = 0; rd_cyc[i] = 0; low_run[i] = 0;
      n_rd[i] = 0; rd_viol[i] = 0; n_done[i] = 0;
    end
    forever begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < 2; i++) begin
        if (!rstn) begin
          in_f[i] = 0; low_run[i] = 0; clr_cur(i);
        end else begin
          if (fifo_rd[i]) begin
            n_rd[i]++; rd_cyc[i] = cyc;
            if (fifo_empty[i]) rd_viol[i]++;
          end
          if (word_done[i]) n_done[i]++;
          if (ser_frame[i]) begin
            if (!in_f[i]) begin
              clr_cur(i);
              cur[i].lat = cyc - rd_cyc[i];
              cur[i].gap = low_run[i];
              in_f[i] = 1;
            end else if (!ser_bit_stb[i] && ser_data[i] !== prev[i]) begin
              cur[i].unstable = 1;
            end
            low_run[i] = 0;
            cur[i].ncyc++;
            if (ser_bit_stb[i]) begin
              cur[i].bits = {cur[i].bits[15:0], ser_data[i]};
              cur[i].nbits++;
            end
            prev[i] = ser_data[i];
            if (word_done[i]) obs[i].push_back(cur[i]);
          end else begin
            in_f[i] = 0;
            low_run[i]++;
          end
        end
      end
    end
  end

  task automatic push_word(input int lane, input logic [15:0] w);
    fq[lane].push_back(w);
    expq[lane].push_back(lane == 1 ? {w, ^w} : {1'b0, w});
  endtask

  task automatic test_reset();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        en[i] = 1'($urandom_range(0, 1));
        fq[i].push_back(16'($urandom));
      end
      #1;
      for (int i = 0; i < 2; i++) begin
        tests++;
        if ({fifo_rd[i], ser_data[i], ser_frame[i], ser_bit_stb[i], busy[i],
             word_done[i], word_cnt[i]} !== 22'd0) begin
          fails++;
          $display("FAIL reset_outs lane%0d cyc%0d: got rd%b d%b f%b s%b b%b w%b cnt%0h, exp all 0",
                   i, c, fifo_rd[i], ser_data[i], ser_frame[i], ser_bit_stb[i], busy[i],
                   word_done[i], word_cnt[i]);
        end
      end
    end
    en[0] = 0; en[1] = 0;
    fq[0].delete(); fq[1].delete();
    repeat (3) @(negedge clk);
    rstn = 1;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      tests++;
      if (busy[i] !== 1'b0 || word_cnt[i] !== 16'd0 || fifo_rd[i] !== 1'b0) begin
        fails++;
        $display("FAIL post_reset lane%0d: got busy %b cnt %0h rd %b, exp 0 0 0",
                 i, busy[i], word_cnt[i], fifo_rd[i]);
      end
    end
  endtask

  task automatic test_single();
    frm_t f; logic [16:0] e; int rd0;
    rd0 = n_rd[0];
    push_word(0, 16'hA5C3);
    en[0] = 1;
    for (int k = 0; k < 300 && obs[0].size() < 1; k++) @(negedge clk);
    tests++;
    if (obs[0].size() < 1) begin
      fails++; $display("FAIL single_timeout: got 0 frames, exp 1");
      return;
    end
    f = obs[0].pop_front(); e = expq[0].pop_front();
    tests++;
    if (f.bits !== e) begin fails++; $display("FAIL single_bits: got %h exp %h", f.bits, e); end
    tests++;
    if (f.nbits !== 16 || f.ncyc !== 64) begin
      fails++; $display("FAIL single_len: got %0d stb %0d cyc, exp 16 64", f.nbits, f.ncyc);
    end
    tests++;
    if (f.lat !== 2 || f.unstable) begin
      fails++; $display("FAIL single_lat: got lat %0d unstable %b, exp 2 0", f.lat, f.unstable);
    end
    repeat (8) @(negedge clk);
    en[0] = 0;
    tests++;
    if (n_rd[0] - rd0 !== 1 || word_cnt[0] !== 16'd1 || n_done[0] !== 1 || busy[0] !== 1'b0) begin
      fails++;
      $display("FAIL single_counts: got rd %0d cnt %0d done %0d busy %b, exp 1 1 1 0",
               n_rd[0] - rd0, word_cnt[0], n_done[0], busy[0]);
    end
  endtask

  task automatic test_back_to_back();
    frm_t f; logic [16:0] e; logic [15:0] base;
    logic [15:0] words [3];
    words[0] = 16'h0001; words[1] = 16'h8000; words[2] = 16'hFFFF;
    base = word_cnt[0];
    for (int j = 0; j < 3; j++) push_word(0, words[j]);
    en[0] = 1;
    for (int k = 0; k < 600 && obs[0].size() < 3; k++) @(negedge clk);
    tests++;
    if (obs[0].size() < 3) begin
      fails++; $display("FAIL b2b_timeout: got %0d frames, exp 3", obs[0].size());
      en[0] = 0;
      return;
    end
    for (int j = 0; j < 3; j++) begin
      f = obs[0].pop_front(); e = expq[0].pop_front();
      tests++;
      if (f.bits !== e || f.ncyc !== 64) begin
        fails++; $display("FAIL b2b_frame%0d: got %h/%0d exp %h/64", j, f.bits, f.ncyc, e);
      end
      if (j > 0) begin
        tests++;
        if (f.gap !== GP + 3) begin
          fails++; $display("FAIL b2b_gap%0d: got %0d exp %0d", j, f.gap, GP + 3);
        end
      end
    end
    repeat (8) @(negedge clk);
    en[0] = 0;
    tests++;
    if (word_cnt[0] !== base + 16'd3 || rd_viol[0] !== 0) begin
      fails++;
      $display("FAIL b2b_counts: got cnt %0d viol %0d, exp %0d 0", word_cnt[0], rd_viol[0], base + 16'd3);
    end
  endtask

  task automatic test_parity();
    frm_t f; logic [16:0] e;
    push_word(1, 16'h0001);
    push_word(1, 16'h0003);
    en[1] = 1;
    for (int k = 0; k < 400 && obs[1].size() < 2; k++) @(negedge clk);
    tests++;
    if (obs[1].size() < 2) begin
      fails++; $display("FAIL parity_timeout: got %0d frames, exp 2", obs[1].size());
      en[1] = 0;
      return;
    end
    for (int j = 0; j < 2; j++) begin
      f = obs[1].pop_front(); e = expq[1].pop_front();
      tests++;
      if (f.bits !== e) begin fails++; $display("FAIL parity_bits%0d: got %h exp %h", j, f.bits, e); end
      tests++;
      if (f.nbits !== 17 || f.ncyc !== 68) begin
        fails++; $display("FAIL parity_len%0d: got %0d/%0d exp 17/68", j, f.nbits, f.ncyc);
      end
      tests++;
      if (f.bits[0] !== (j == 0 ? 1'b1 : 1'b0)) begin
        fails++; $display("FAIL parity_last%0d: got %b exp %b", j, f.bits[0], j == 0);
      end
    end
    en[1] = 0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_en_drop();
    frm_t f; logic [16:0] e; int rd0; logic [15:0] base;
    rd0 = n_rd[0]; base = word_cnt[0];
    push_word(0, 16'h1234);
    push_word(0, 16'h5678);
    en[0] = 1;
    for (int k = 0; k < 300 && !(in_f[0] && cur[0].nbits == 5); k++) @(negedge clk);
    en[0] = 0;
    repeat (250) @(negedge clk);
    tests++;
    if (obs[0].size() !== 1) begin
      fails++; $display("FAIL endrop_frames: got %0d exp 1", obs[0].size());
    end else begin
      f = obs[0].pop_front(); e = expq[0].pop_front();
      tests++;
      if (f.bits !== e || f.nbits !== 16) begin
        fails++; $display("FAIL endrop_bits: got %h/%0d exp %h/16", f.bits, f.nbits, e);
      end
    end
    tests++;
    if (n_rd[0] - rd0 !== 1 || fq[0].size() !== 1 || word_cnt[0] !== base + 16'd1 || busy[0] !== 1'b0) begin
      fails++;
      $display("FAIL endrop_stop: got rd %0d left %0d cnt %0d busy %b, exp 1 1 %0d 0",
               n_rd[0] - rd0, fq[0].size(), word_cnt[0], busy[0], base + 16'd1);
    end
    fq[0].delete(); expq[0].delete(); obs[0].delete();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid_frame();
    frm_t f; logic [16:0] e;
    push_word(0, 16'hC3A5);
    en[0] = 1;
    for (int k = 0; k < 300 && !(in_f[0] && cur[0].nbits == 8); k++) @(negedge clk);
    tests++;
    if (!(in_f[0] && ser_frame[0] === 1'b1)) begin
      fails++; $display("FAIL rst_mid_setup: got frame %b exp 1", ser_frame[0]);
    end
    #2 rstn = 0;
    #1;
    tests++;
    if (ser_frame[0] !== 1'b0 || busy[0] !== 1'b0 || word_cnt[0] !== 16'd0) begin
      fails++;
      $display("FAIL rst_mid_async: got frame %b busy %b cnt %0d, exp 0 0 0",
               ser_frame[0], busy[0], word_cnt[0]);
    end
    expq[0].delete();
    @(negedge clk);
    push_word(0, 16'h3C96);
    repeat (3) @(negedge clk);
    rstn = 1;
    for (int k = 0; k < 300 && obs[0].size() < 1; k++) @(negedge clk);
    tests++;
    if (obs[0].size() !== 1) begin
      fails++; $display("FAIL rst_mid_frames: got %0d exp 1", obs[0].size());
    end else begin
      f = obs[0].pop_front(); e = expq[0].pop_front();
      tests++;
      if (f.bits !== e || f.ncyc !== 64 || f.lat !== 2) begin
        fails++;
        $display("FAIL rst_mid_fresh: got %h/%0d/lat%0d exp %h/64/lat2", f.bits, f.ncyc, f.lat, e);
      end
    end
    en[0] = 0;
    repeat (6) @(negedge clk);
    tests++;
    if (word_cnt[0] !== 16'd1 || busy[0] !== 1'b0) begin
      fails++; $display("FAIL rst_mid_cnt: got %0d busy %b exp 1 0", word_cnt[0], busy[0]);
    end
  endtask

  initial begin
    en[0] = 0; en[1] = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_parity();
    test_en_drop();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, exp finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
